// File: rtl/mul_arb_if.sv
// rtl/mul_arb_if.sv - requester and multiplier bus bundle for the shared-multiplier arbiter
interface mul_arb_if #(
    parameter int DW = 16
);
    logic          req0;
    logic [DW-1:0] m0;
    logic [DW-1:0] q0;
    logic          sgn0;
    logic          ack0;
    logic [2*DW-1:0] res0;
    logic          err0;

    logic          req1;
    logic [DW-1:0] m1;
    logic [DW-1:0] q1;
    logic          sgn1;
    logic          ack1;
    logic [2*DW-1:0] res1;
    logic          err1;

    logic          mul_start;
    logic [3:0]    mul_dtype;
    logic [DW-1:0] mul_m;
    logic [DW-1:0] mul_q;
    logic          mul_done;
    logic [2*DW-1:0] mul_result;
    logic          busy;

    modport slave (
        input  req0, m0, q0, sgn0,
        input  req1, m1, q1, sgn1,
        input  mul_done, mul_result,
        output ack0, res0, err0,
        output ack1, res1, err1,
        output mul_start, mul_dtype, mul_m, mul_q, busy
    );

    modport master (
        output req0, m0, q0, sgn0,
        output req1, m1, q1, sgn1,
        output mul_done, mul_result,
        input  ack0, res0, err0,
        input  ack1, res1, err1,
        input  mul_start, mul_dtype, mul_m, mul_q, busy
    );
endinterface

// File: rtl/mul_arb.sv
// rtl/mul_arb.sv - round-robin arbiter sharing one iterative multiplier between two requesters
module mul_arb #(
    parameter int DW      = 16,
    parameter int TIMEOUT = 40
) (
    input logic      clk,
    input logic      rst,
    mul_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
    localparam logic [3:0] DT_IDLE = 4'h0;
    localparam logic [3:0] DT_UNS  = 4'h1;
    localparam logic [3:0] DT_SGN  = 4'h2;

    state_t          state, state_d;
    logic            owner, owner_d;
    logic            last_grant, last_grant_d;
    logic [TW-1:0]   timer, timer_d;
    logic            grant;
    logic            done_or_timeout;

    logic            start_r, start_d;
    logic [3:0]      dtype_r, dtype_d;
    logic [DW-1:0]   m_r, m_d;
    logic [DW-1:0]   q_r, q_d;
    logic            busy_r, busy_d;
    logic            ack0_r, ack0_d, ack1_r, ack1_d;
    logic            err0_r, err0_d, err1_r, err1_d;
    logic [2*DW-1:0] res0_r, res0_d, res1_r, res1_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            timer      <= '0;
            start_r    <= 1'b0;
            dtype_r    <= DT_IDLE;
            m_r        <= '0;
            q_r        <= '0;
            busy_r     <= 1'b0;
            ack0_r     <= 1'b0;
            ack1_r     <= 1'b0;
            err0_r     <= 1'b0;
            err1_r     <= 1'b0;
            res0_r     <= '0;
            res1_r     <= '0;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            last_grant <= last_grant_d;
            timer      <= timer_d;
            start_r    <= start_d;
            dtype_r    <= dtype_d;
            m_r        <= m_d;
            q_r        <= q_d;
            busy_r     <= busy_d;
            ack0_r     <= ack0_d;
            ack1_r     <= ack1_d;
            err0_r     <= err0_d;
            err1_r     <= err1_d;
            res0_r     <= res0_d;
            res1_r     <= res1_d;
        end
    end

    // Outputs are computed one state ahead so every port comes straight from a flop.
    always_comb begin
        state_d         = state;
        owner_d         = owner;
        last_grant_d    = last_grant;
        timer_d         = timer;
        start_d         = 1'b0;
        dtype_d         = dtype_r;
        m_d             = m_r;
        q_d             = q_r;
        busy_d          = busy_r;
        ack0_d          = 1'b0;
        ack1_d          = 1'b0;
        err0_d          = err0_r;
        err1_d          = err1_r;
        res0_d          = res0_r;
        res1_d          = res1_r;
        grant           = 1'b0;
        done_or_timeout = bus.mul_done || (timer == TLIM);

        case (state)
            IDLE: begin
                dtype_d = DT_IDLE;
                if (bus.req0 || bus.req1) begin
                    grant   = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
                    owner_d = grant;
                    m_d     = grant ? bus.m1 : bus.m0;
                    q_d     = grant ? bus.q1 : bus.q0;
                    dtype_d = (grant ? bus.sgn1 : bus.sgn0) ? DT_SGN : DT_UNS;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer + TW'(1);
                // A done pulse in the timeout cycle still returns the real product.
                if (done_or_timeout) begin
                    state_d = RESP;
                    if (owner) begin
                        ack1_d = 1'b1;
                        res1_d = bus.mul_done ? bus.mul_result : '0;
                        err1_d = ~bus.mul_done;
                    end else begin
                        ack0_d = 1'b1;
                        res0_d = bus.mul_done ? bus.mul_result : '0;
                        err0_d = ~bus.mul_done;
                    end
                end
            end
            RESP: begin
                last_grant_d = owner;
                dtype_d      = DT_IDLE;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                dtype_d = DT_IDLE;
            end
        endcase
    end

    assign bus.mul_start = start_r;
    assign bus.mul_dtype = dtype_r;
    assign bus.mul_m     = m_r;
    assign bus.mul_q     = q_r;
    assign bus.busy      = busy_r;
    assign bus.ack0      = ack0_r;
    assign bus.ack1      = ack1_r;
    assign bus.res0      = res0_r;
    assign bus.res1      = res1_r;
    assign bus.err0      = err0_r;
    assign bus.err1      = err1_r;
endmodule

// File: tb/tb_mul_arb.sv
// tb/tb_mul_arb.sv - scoreboard bench for mul_arb with a behavioural multiplier
module tb_mul_arb;
    localparam int TIMEOUT = 40;

    typedef struct {
        logic [15:0] m;
        logic [15:0] q;
        logic        sgn;
    } op_t;

    typedef struct {
        logic [31:0] res;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    mul_arb_if #(.DW(16)) bus ();

    mul_arb #(.DW(16), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    op_t  opq0[$], opq1[$];
    exp_t expq0[$], expq1[$];
    int   ack_log[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   starts = 0;
    int   last_start_cyc = 0;
    int   last_done_cyc = 0;
    int   lat = 17;
    bit   hang = 0;
    bit   chk_dtype = 0;
    logic [3:0] exp_dtype = 4'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic push(input int who, input logic [15:0] m, input logic [15:0] q, input logic s,
                        input logic [31:0] r, input logic e, input bit want_ack);
        op_t  o;
        exp_t x;
        o.m = m; o.q = q; o.sgn = s;
        x.res = r; x.err = e;
        if (who == 0) begin
            opq0.push_back(o);
            if (want_ack) expq0.push_back(x);
        end else begin
            opq1.push_back(o);
            if (want_ack) expq1.push_back(x);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((opq0.size() != 0 || opq1.size() != 0 || expq0.size() != 0 || expq1.size() != 0 ||
                bus.busy || bus.req0 || bus.req1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Requester 0: holds req and operands until ack, chains the next queued op without dropping req.
    initial begin : rq0
        bit  active;
        op_t o;
        active = 0;
        bus.req0 = 1'b0; bus.m0 = '0; bus.q0 = '0; bus.sgn0 = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0;
                bus.req0 = 1'b0;
            end else begin
                if (active && bus.ack0) begin
                    active = 0;
                    bus.req0 = 1'b0;
                end
                if (!active && opq0.size() != 0) begin
                    o = opq0.pop_front();
                    bus.m0 = o.m; bus.q0 = o.q; bus.sgn0 = o.sgn;
                    bus.req0 = 1'b1;
                    active = 1;
                end
            end
        end
    end

    initial begin : rq1
        bit  active;
        op_t o;
        active = 0;
        bus.req1 = 1'b0; bus.m1 = '0; bus.q1 = '0; bus.sgn1 = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0;
                bus.req1 = 1'b0;
            end else begin
                if (active && bus.ack1) begin
                    active = 0;
                    bus.req1 = 1'b0;
                end
                if (!active && opq1.size() != 0) begin
                    o = opq1.pop_front();
                    bus.m1 = o.m; bus.q1 = o.q; bus.sgn1 = o.sgn;
                    bus.req1 = 1'b1;
                    active = 1;
                end
            end
        end
    end

    // Multiplier model: not reset, so a stale done can follow an arbiter reset.
    initial begin : mult
        int cnt;
        logic [31:0] prod;
        cnt = 0;
        prod = '0;
        bus.mul_done = 1'b0;
        bus.mul_result = '0;
        forever begin
            @(negedge clk);
            bus.mul_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && !hang) begin
                    bus.mul_done = 1'b1;
                    bus.mul_result = prod;
                    last_done_cyc = cyc;
                end
            end
            if (bus.mul_start) begin
                cnt = lat;
                if (bus.mul_dtype == 4'h2) prod = $signed(bus.mul_m) * $signed(bus.mul_q);
                else                       prod = bus.mul_m * bus.mul_q;
            end
        end
    end

    initial begin : monitor
        bit   outstanding;
        exp_t x;
        outstanding = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                outstanding = 0;
            end else begin
                if (!bus.busy) chk("idle_dtype", 32'(bus.mul_dtype), 32'h0);
                if (bus.busy && chk_dtype) chk("busy_dtype", 32'(bus.mul_dtype), 32'(exp_dtype));
                if (bus.mul_start) begin
                    chk("single_start", 32'(outstanding), 32'd0);
                    outstanding = 1;
                    starts++;
                    last_start_cyc = cyc;
                end
                if (bus.ack0 && bus.ack1) chk("dual_ack", 32'd1, 32'd0);
                if (bus.ack0) begin
                    outstanding = 0;
                    ack_log.push_back(0);
                    if (expq0.size() == 0) begin
                        chk("spurious_ack0", 32'd1, 32'd0);
                    end else begin
                        x = expq0.pop_front();
                        chk("res0", bus.res0, x.res);
                        chk("err0", 32'(bus.err0), 32'(x.err));
                        if (x.err) chk("lat_timeout0", 32'(cyc - last_start_cyc), 32'(TIMEOUT + 1));
                        else       chk("lat_done0", 32'(cyc - last_done_cyc), 32'd1);
                    end
                end
                if (bus.ack1) begin
                    outstanding = 0;
                    ack_log.push_back(1);
                    if (expq1.size() == 0) begin
                        chk("spurious_ack1", 32'd1, 32'd0);
                    end else begin
                        x = expq1.pop_front();
                        chk("res1", bus.res1, x.res);
                        chk("err1", 32'(bus.err1), 32'(x.err));
                        if (x.err) chk("lat_timeout1", 32'(cyc - last_start_cyc), 32'(TIMEOUT + 1));
                        else       chk("lat_done1", 32'(cyc - last_done_cyc), 32'd1);
                    end
                end
            end
        end
    end

    initial begin : main
        int s0;
        int n;
        int log_before;
        int exp_order[6];
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ack", 32'({bus.ack0, bus.ack1}), 32'd0);
        chk("rst_start", 32'(bus.mul_start), 32'd0);
        chk("rst_dtype", 32'(bus.mul_dtype), 32'd0);
        chk("rst_res", bus.res0 | bus.res1, 32'd0);

        // Requester 0 alone, unsigned
        chk_dtype = 1; exp_dtype = 4'h1; lat = 17;
        ack_log.delete();
        @(posedge clk); #1;
        push(0, 16'd3, 16'd5, 1'b0, 32'h0000_000F, 1'b0, 1);
        wait_drain("drain_single", 100);
        chk("single_ack_count", 32'(ack_log.size()), 32'd1);
        chk("single_owner", 32'(ack_log[0]), 32'd0);

        // Simultaneous requests after reset: requester 0 wins the tie
        do_reset();
        ack_log.delete();
        s0 = starts;
        @(posedge clk); #1;
        push(0, 16'd2, 16'd7, 1'b0, 32'd14, 1'b0, 1);
        push(1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 1'b0, 1);
        wait_drain("drain_tie", 200);
        chk("tie_count", 32'(ack_log.size()), 32'd2);
        chk("tie_first", 32'(ack_log[0]), 32'd0);
        chk("tie_second", 32'(ack_log[1]), 32'd1);
        chk("tie_starts", 32'(starts - s0), 32'd2);

        // Signed request on requester 1
        exp_dtype = 4'h2;
        @(posedge clk); #1;
        push(1, 16'hFFFE, 16'd3, 1'b1, 32'hFFFF_FFFA, 1'b0, 1);
        wait_drain("drain_signed", 100);

        // Hung multiplier times out, then a normal request completes
        exp_dtype = 4'h1; hang = 1;
        @(posedge clk); #1;
        push(0, 16'd4, 16'd4, 1'b0, 32'd0, 1'b1, 1);
        wait_drain("drain_timeout", 150);
        hang = 0;
        @(posedge clk); #1;
        push(0, 16'd4, 16'd4, 1'b0, 32'd16, 1'b0, 1);
        wait_drain("drain_after_timeout", 100);

        // Reset in WAIT abandons the operation; the stale done must be ignored
        @(posedge clk); #1;
        push(0, 16'd9, 16'd9, 1'b0, 32'd81, 1'b0, 0);
        n = 0;
        while (!bus.mul_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_test_start_seen", 32'(n < 50), 32'd1);
        repeat (5) @(negedge clk);
        log_before = ack_log.size();
        do_reset();
        @(negedge clk);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_ack", 32'({bus.ack0, bus.ack1}), 32'd0);
        chk("midrst_dtype", 32'(bus.mul_dtype), 32'd0);
        chk("midrst_mq", 32'({bus.mul_m, bus.mul_q}), 32'd0);
        chk("midrst_res", bus.res0 | bus.res1, 32'd0);
        chk("midrst_err", 32'({bus.err0, bus.err1}), 32'd0);
        repeat (20) @(negedge clk);
        chk("stale_done_no_ack", 32'(ack_log.size()), 32'(log_before));
        chk("stale_done_busy", 32'(bus.busy), 32'd0);

        // Continuous requests from both sides alternate, starting with requester 0
        chk_dtype = 0; lat = 3;
        ack_log.delete();
        @(posedge clk); #1;
        push(0, 16'd1, 16'd1, 1'b0, 32'd1, 1'b0, 1);
        push(0, 16'd100, 16'd200, 1'b0, 32'h0000_4E20, 1'b0, 1);
        push(0, 16'h8000, 16'd2, 1'b0, 32'h0001_0000, 1'b0, 1);
        push(1, 16'hFFFF, 16'hFFFF, 1'b1, 32'd1, 1'b0, 1);
        push(1, 16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF_0001, 1'b0, 1);
        push(1, 16'h1234, 16'h0010, 1'b0, 32'h0001_2340, 1'b0, 1);
        wait_drain("drain_alternate", 400);
        exp_order = '{0, 1, 0, 1, 0, 1};
        chk("alt_count", 32'(ack_log.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk($sformatf("alt_grant%0d", i), 32'(ack_log[i]), 32'(exp_order[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : backstop
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/mul_arb.md
Name: mul_arb

Overview:
- Arbiter and sequencer that shares one iterative 16x16 multiplier between two requesters, typically the UART command parser and the expression evaluator.
- Accepts operand requests over a req/ack handshake and picks one with round-robin.
- Drives the multiplier's start/dtype/operand inputs, waits for its done pulse and returns the 32-bit product to the winning requester.
- A watchdog stops a hung multiplier from blocking the block.

Parameters:
- DW, 16: operand width; product width is 2*DW.
- TIMEOUT, 40: maximum cycles spent in WAIT before the operation is aborted with an error.

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0  in  1  requester 0 request; level, held until ack0
- m0  in  DW  requester 0 multiplicand
- q0  in  DW  requester 0 multiplier
- sgn0  in  1  requester 0 type: 1 = signed, 0 = unsigned
- ack0  out  1  one-cycle response strobe to requester 0
- res0  out  2*DW  product for requester 0; valid while ack0=1
- err0  out  1  timeout flag; valid while ack0=1
- req1, m1, q1, sgn1, ack1, res1, err1: same as requester 0, for requester 1
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_dtype  out  4  4'h1 = unsigned, 4'h2 = signed, 4'h0 = idle
- mul_m  out  DW  multiplicand to the multiplier
- mul_q  out  DW  multiplier operand to the multiplier
- mul_done  in  1  one-cycle completion pulse from the multiplier
- mul_result  in  2*DW  product from the multiplier; valid in the mul_done cycle
- busy  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a clk edge) returns state to IDLE and clears every output to 0.
- Reset sets last_grant=1, so requester 0 wins the first tie.
- Reset sets the watchdog timer and the latched owner to 0.
- Reset has priority in any state. In WAIT it abandons the operation: no ack is issued and the multiplier's later done pulse is ignored.

State machine (IDLE, ISSUE, WAIT, RESP):
- IDLE:
  - If req0 or req1 is high, select one requester.
  - If only one is high, grant it.
  - If both are high, grant the one not equal to last_grant.
  - Latch owner, m, q and sgn into internal registers, then go to ISSUE.
  - With no request, stay in IDLE with mul_dtype=0.
- ISSUE:
  - Assert mul_start=1 for exactly this cycle.
  - Drive mul_dtype = sgn ? 4'h2 : 4'h1, with mul_m and mul_q from the latched operands.
  - Clear the timer and go to WAIT.
- WAIT:
  - Hold mul_dtype, mul_m and mul_q stable; mul_start=0.
  - The timer increments each cycle.
  - When mul_done=1, capture mul_result, set the error bit to 0 and go to RESP.
  - Otherwise, when timer==TIMEOUT-1, set result to 0, set the error bit to 1 and go to RESP.
  - If done and timeout occur in the same cycle, done wins (err=0).
- RESP:
  - Pulse ack of the owner for one cycle, with res and err of the owner valid in that cycle.
  - The other requester's ack stays 0.
  - Set last_grant=owner, drive mul_dtype to 0 and return to IDLE.

Handshake rules:
- A requester holds req and its operands stable until it samples ack=1.
- It drops req in the cycle after ack, which is the cycle the arbiter is back in IDLE. A req still high in that IDLE cycle counts as a new request.
- A req arriving while the block is busy waits. The operands of the pending requester are not sampled until its grant.
- res and err hold their last value after ack falls; they are only guaranteed valid during ack.

Latency:
- With req high in IDLE at cycle 0: mul_start at cycle 1, WAIT from cycle 2.
- mul_done at cycle k gives ack at cycle k+1.
- Minimum overhead is 3 cycles on top of the multiplier's own latency.

Fairness:
- Under continuous requests from both sides, grants strictly alternate.
- The arbiter never issues a second start before the current operation has reached RESP.

Test Plan:
- Requester 0 alone, m0=3, q0=5, sgn0=0; multiplier model pulses done 17 cycles after start -> mul_dtype=4'h1 while busy; ack0 at done+1 with res0=32'h0000_000F, err0=0; ack1 never asserts.
- req0 and req1 rise in the same IDLE cycle after reset (m0=2,q0=7; m1=16'hFFFF,q1=16'hFFFF, both unsigned) -> requester 0 served first (res0=14), then requester 1 (res1=32'hFFFE_0001). Exactly one mul_start per operation.
- Signed request on requester 1, sgn1=1, m1=16'hFFFE, q1=3; model returns 32'hFFFF_FFFA -> mul_dtype=4'h2 in ISSUE and WAIT; res1=32'hFFFF_FFFA.
- Model never pulses done -> ack0 at exactly TIMEOUT+1 cycles after the ISSUE cycle, with err0=1 and res0=0; a following request completes normally.
- rst pulsed mid-WAIT, then the model's stale done pulse arrives -> no ack, busy=0, all outputs 0; after reset a tie grants requester 0.
- Both requesters hold req continuously for 6 operations -> grants alternate 0,1,0,1,0,1; mul_dtype=0 in every IDLE cycle.
